freq_meter_gate: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 25 ++
 rtl/freq_meter_gate_sync_edge_det.sv | 66 ++++++
 rtl/freq_meter_gate.sv | 132 +++++++++++++
 tb/tb_freq_meter_gate.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: FSM encoding,
// default sizing constants and the input synchronizer depth.
package freq_meter_pkg;

  // Two-state controller: idle, or counting inside a gate window.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } state_t;

  // Board clock and the 1 s gate that makes the result read directly in Hz.
  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_GATE_CYCLES = DEF_CLK_HZ;
  // 2^26-1 exceeds the highest countable rate (CLK_HZ/2) for a 1 s gate.
  localparam int DEF_CNT_W       = 26;

  // Number of flops in the metastability synchronizer.
  localparam int SYNC_STAGES     = 2;

  // Width needed to hold gate positions 1..gate_cycles.
  function automatic int gate_cnt_width(input int gate_cycles);
    return $clog2(gate_cycles + 1);
  endfunction

endpackage

// File: rtl/freq_meter_gate_sync_edge_det.sv
// Input conditioning for the frequency meter: 2-flop synchronizer,
// optional 3-sample majority filter, then a rising-edge pulse.
// Optional feature macro: FREQ_METER_DEGLITCH_EN (majority filter, +2 cycles
// latency, rejects single-cycle pulses).
module sync_edge_det
  import freq_meter_pkg::*;
(
  input  logic Clk50MHz,
  input  logic Rst_n,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level;
  logic                   level_d_reg;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge Clk50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
    end
  end

`ifdef FREQ_METER_DEGLITCH_EN
  logic [1:0] hist_reg;
  logic       filt_reg;
  logic       sync_out;
  logic       majority;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  // Two-of-three vote: a level must persist for two samples to pass.
  assign majority = (sync_out & hist_reg[0]) |
                    (sync_out & hist_reg[1]) |
                    (hist_reg[0] & hist_reg[1]);

  // Keep the last two synchronized samples and register the vote.
  always_ff @(posedge Clk50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      hist_reg <= '0;
      filt_reg <= 1'b0;
    end else begin
      hist_reg <= {hist_reg[0], sync_out};
      filt_reg <= majority;
    end
  end

  assign level = filt_reg;
`else
  assign level = sync_reg[SYNC_STAGES-1];
`endif

  // Delay the conditioned level by one cycle for edge detection.
  always_ff @(posedge Clk50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      level_d_reg <= 1'b0;
    end else begin
      level_d_reg <= level;
    end
  end

  assign edge_out = level & ~level_d_reg;

endmodule

// File: rtl/freq_meter_gate.sv
// Gated frequency meter: counts rising edges of SigIn over GATE_CYCLES
// clocks and publishes the count in Freq with a one-cycle FreqValid pulse.
// Gates run back-to-back while Enable is high; Enable low aborts a gate.
// Optional feature macro: FREQ_METER_DEGLITCH_EN (see sync_edge_det).
module freq_meter_gate
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             Clk50MHz,
  input  logic             Rst_n,
  input  logic             Enable,
  input  logic             SigIn,
  output logic [CNT_W-1:0] Freq,
  output logic             FreqValid,
  output logic             Overflow,
  output logic             Busy
);

  localparam int              GC_W      = gate_cnt_width(GATE_CYCLES);
  localparam logic [GC_W-1:0] GATE_LAST = GC_W'(GATE_CYCLES);
  localparam logic [GC_W-1:0] GATE_ONE  = GC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [GC_W-1:0]  gate_cnt_reg, gate_cnt_next;
  logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
  logic             sat_reg, sat_next;
  logic [CNT_W-1:0] freq_reg, freq_next;
  logic             ovf_reg, ovf_next;
  logic             valid_reg, valid_next;

  logic             sig_edge;
  logic [CNT_W-1:0] cnt_upd;
  logic             sat_upd;

  sync_edge_det u_sync_edge_det (
    .Clk50MHz (Clk50MHz),
    .Rst_n    (Rst_n),
    .async_in (SigIn),
    .edge_out (sig_edge)
  );

  // Edge count including this cycle's edge, saturating at all-ones; the
  // saturation flag records an edge that could not be counted.
  always_comb begin
    cnt_upd = edge_cnt_reg;
    sat_upd = sat_reg;
    if (sig_edge) begin
      if (edge_cnt_reg != CNT_MAX) begin
        cnt_upd = edge_cnt_reg + CNT_W'(1);
      end else begin
        sat_upd = 1'b1;
      end
    end
  end

  // Next-state and output-register logic for the gate controller.
  always_comb begin
    state_next    = state_reg;
    gate_cnt_next = gate_cnt_reg;
    edge_cnt_next = edge_cnt_reg;
    sat_next      = sat_reg;
    freq_next     = freq_reg;
    ovf_next      = ovf_reg;
    valid_next    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (Enable) begin
          state_next    = ST_GATE;
          gate_cnt_next = GATE_ONE;
          edge_cnt_next = '0;
          sat_next      = 1'b0;
        end
      end
      ST_GATE: begin
        if (gate_cnt_reg == GATE_LAST) begin
          // Closing cycle completes even if Enable has just dropped.
          freq_next     = cnt_upd;
          ovf_next      = sat_upd;
          valid_next    = 1'b1;
          gate_cnt_next = GATE_ONE;
          edge_cnt_next = '0;
          sat_next      = 1'b0;
          state_next    = Enable ? ST_GATE : ST_IDLE;
        end else if (!Enable) begin
          // Abort: partial count is discarded, published result untouched.
          state_next    = ST_IDLE;
          gate_cnt_next = GATE_ONE;
          edge_cnt_next = '0;
          sat_next      = 1'b0;
        end else begin
          gate_cnt_next = gate_cnt_reg + GATE_ONE;
          edge_cnt_next = cnt_upd;
          sat_next      = sat_upd;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and published results.
  always_ff @(posedge Clk50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= ST_IDLE;
      gate_cnt_reg <= GATE_ONE;
      edge_cnt_reg <= '0;
      sat_reg      <= 1'b0;
      freq_reg     <= '0;
      ovf_reg      <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gate_cnt_reg <= gate_cnt_next;
      edge_cnt_reg <= edge_cnt_next;
      sat_reg      <= sat_next;
      freq_reg     <= freq_next;
      ovf_reg      <= ovf_next;
      valid_reg    <= valid_next;
    end
  end

  assign Freq      = freq_reg;
  assign FreqValid = valid_reg;
  assign Overflow  = ovf_reg;
  assign Busy      = (state_reg == ST_GATE);

endmodule

// File: tb/tb_freq_meter_gate.sv
// Directed bench for freq_meter_gate: GATE_CYCLES=100 with CNT_W=8 (main)
// and CNT_W=3 (saturation) instances sharing the same stimulus.
module tb_freq_meter_gate;

  localparam int GATE = 100;
`ifdef FREQ_METER_DEGLITCH_EN
  localparam int GLITCH_EXP = 0;
`else
  localparam int GLITCH_EXP = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sig_in;
  logic [7:0] freq;
  logic       freq_valid, overflow, busy;
  logic [2:0] freq_s;
  logic       valid_s, ovf_s, busy_s;

  int checks = 0;
  int errors = 0;
  int sig_mode = 0;    // 0 low, 1 high, 2 square wave, 3 one-cycle pulses
  int sig_period = 10;
  int n;
  int pulses;

  always #5 clk = ~clk;

  freq_meter_gate #(.GATE_CYCLES(GATE), .CNT_W(8)) dut (
    .Clk50MHz (clk),
    .Rst_n    (rst_n),
    .Enable   (enable),
    .SigIn    (sig_in),
    .Freq     (freq),
    .FreqValid(freq_valid),
    .Overflow (overflow),
    .Busy     (busy)
  );

  freq_meter_gate #(.GATE_CYCLES(GATE), .CNT_W(3)) dut_sat (
    .Clk50MHz (clk),
    .Rst_n    (rst_n),
    .Enable   (enable),
    .SigIn    (sig_in),
    .Freq     (freq_s),
    .FreqValid(valid_s),
    .Overflow (ovf_s),
    .Busy     (busy_s)
  );

  // Signal generator: updates SigIn 2 time units after each rising edge.
  initial begin
    int phase;
    phase  = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      phase = phase + 1;
      case (sig_mode)
        0:       sig_in = 1'b0;
        1:       sig_in = 1'b1;
        2:       sig_in = ((phase % sig_period) < (sig_period / 2));
        default: sig_in = ((phase % 10) == 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next FreqValid; n = cycles waited.
  task automatic wait_pulse(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!freq_valid && cnt < 300);
    check("pulse_seen", {31'd0, freq_valid}, 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    check("rst_freq", freq, 0);
    check("rst_valid", freq_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    $display("reset: freq=%0d valid=%0d ovf=%0d busy=%0d", freq, freq_valid, overflow, busy);
    rst_n = 1'b1;

    // Steady square wave, period 10
    sig_mode   = 2;
    sig_period = 10;
    repeat (30) tick();
    check("idle_busy", busy, 0);
    enable = 1'b1;
    tick();
    check("start_busy", busy, 1);
    wait_pulse(n);
    check("first_latency", n, GATE);
    check("sq10_freq", freq, 10);
    check("sq10_ovf", overflow, 0);
    check("sat10_freq", freq_s, 7);
    check("sat10_ovf", ovf_s, 1);
    $display("square p10: latency=%0d freq=%0d ovf=%0d sat_freq=%0d sat_ovf=%0d", n, freq, overflow, freq_s, ovf_s);
    tick();
    check("valid_one_cycle", freq_valid, 0);
    check("freq_stable", freq, 10);
    wait_pulse(n);
    check("back_to_back", n, GATE - 1);
    check("sq10_freq2", freq, 10);

    // Period 20: 5 edges per window, no saturation at CNT_W=3
    sig_period = 20;
    wait_pulse(n);
    wait_pulse(n);
    check("period_b2b", n, GATE);
    check("sq20_freq", freq, 5);
    check("sat20_freq", freq_s, 5);
    check("sat20_ovf", ovf_s, 0);
    $display("square p20: freq=%0d sat_freq=%0d sat_ovf=%0d", freq, freq_s, ovf_s);

    // Abort mid-gate at gate cycle 50
    sig_period = 10;
    wait_pulse(n);
    wait_pulse(n);
    check("pre_abort_freq", freq, 10);
    pulses = 0;
    repeat (49) begin
      tick();
      if (freq_valid) pulses++;
    end
    enable = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", freq_valid, 0);
    repeat (150) begin
      tick();
      if (freq_valid) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_freq_hold", freq, 10);
    $display("abort: busy=%0d pulses=%0d freq=%0d", busy, pulses, freq);
    sig_period = 20;
    repeat (30) tick();
    enable = 1'b1;
    tick();
    wait_pulse(n);
    check("reenable_latency", n, GATE);
    check("reenable_freq", freq, 5);
    $display("re-enable: latency=%0d freq=%0d", n, freq);

    // Reset between clock edges at gate cycle 30
    sig_mode = 0;
    repeat (30) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_freq", freq, 0);
    check("midrst_valid", freq_valid, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sat_freq", freq_s, 0);
    $display("mid-gate reset: freq=%0d busy=%0d sat_freq=%0d", freq, busy, freq_s);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 1);
    wait_pulse(n);
    check("post_rst_latency", n, GATE);
    check("const_low_freq", freq, 0);

    // Single 0->1 step counts once, then a held high counts nothing
    sig_mode = 1;
    wait_pulse(n);
    check("step_freq", freq, 1);
    wait_pulse(n);
    check("const_high_freq", freq, 0);
    sig_mode = 0;
    wait_pulse(n);
    check("fall_freq", freq, 0);
    $display("constant/step: freq=%0d", freq);

    // One-cycle pulses every 10 clocks
    sig_mode = 3;
    wait_pulse(n);
    wait_pulse(n);
    check("glitch_freq", freq, GLITCH_EXP);
    $display("glitch: freq=%0d", freq);

    // Enable drops exactly in the closing cycle: window still completes
    repeat (GATE - 1) tick();
    enable = 1'b0;
    tick();
    check("close_valid", freq_valid, 1);
    check("close_busy", busy, 0);
    check("close_freq", freq, GLITCH_EXP);
    tick();
    check("close_idle_valid", freq_valid, 0);
    check("close_idle_busy", busy, 0);
    $display("enable at close: freq=%0d busy=%0d", freq, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
